// File: rtl/bus_ep_pkg.sv
// Shared constants and helpers for the bus FIFO endpoint.
// Packet IDs live in the top byte of each packet.
package bus_ep_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
  localparam int PKT_MAX = 256;

  // Pull the destination ID out of a zero-extended packet of sz bits.
  function automatic logic [ID_W-1:0] get_dest(
    input logic [PKT_MAX-1:0] pkt,
    input int                 sz
  );
    return pkt[sz-1 -: ID_W];
  endfunction

  // True when a destination ID addresses this endpoint or everyone.
  function automatic logic id_hit(
    input logic [ID_W-1:0] dest,
    input logic [ID_W-1:0] mine
  );
    return (dest == mine) || (dest == BROADCAST_ID);
  endfunction

endpackage

// File: rtl/ep_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// A write is taken when full only if a read happens in the same cycle.
module ep_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [width-1:0] dout
);

  localparam int AW = $clog2(depth);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [width-1:0] mem_q [depth];
  logic             wr_en, rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Next pointer values.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (wr_en) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    if (rd_en) rd_d = rd_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers; storage keeps stale data across reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bus_fifo_endpoint.sv
// Bus endpoint: TX FIFO toward the bus, ID-filtered RX FIFO from it.
// Define BUS_EP_STATS_EN to build the saturating drop counter.
module bus_fifo_endpoint
  import bus_ep_pkg::*;
#(
  parameter int              pckg_sz = 16,
  parameter int              depth   = 8,
  parameter logic [ID_W-1:0] MY_ID   = 8'd0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [pckg_sz-1:0] rx_data,
  output logic [15:0]        drop_cnt
);

  logic               tx_full, tx_empty, tx_wr, tx_rd;
  logic               rx_full, rx_empty, rx_wr, rx_rd;
  logic               hit, drop;
  logic [PKT_MAX-1:0] push_ext;

  assign tx_ready = !tx_full;
  assign pndng    = !tx_empty;
  assign tx_wr    = tx_valid && !tx_full;
  assign tx_rd    = pop && !tx_empty;

  assign rx_valid = !rx_empty;
  assign rx_rd    = rx_valid && rx_ready;

  // Zero-extend the bus packet so the ID helper sees a fixed width.
  always_comb begin
    push_ext                = '0;
    push_ext[pckg_sz-1:0]   = D_push;
  end

  assign hit   = id_hit(get_dest(push_ext, pckg_sz), MY_ID);
  assign rx_wr = push && hit && (!rx_full || rx_rd);
  assign drop  = push && !rx_wr;

  ep_fifo #(
    .width (pckg_sz),
    .depth (depth)
  ) u_tx (
    .clk   (clk),
    .rst_n (reset),
    .push  (tx_wr),
    .pop   (tx_rd),
    .din   (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .dout  (D_pop)
  );

  ep_fifo #(
    .width (pckg_sz),
    .depth (depth)
  ) u_rx (
    .clk   (clk),
    .rst_n (reset),
    .push  (rx_wr),
    .pop   (rx_rd),
    .din   (D_push),
    .full  (rx_full),
    .empty (rx_empty),
    .dout  (rx_data)
  );

`ifdef BUS_EP_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of filtered or overflowed bus packets.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign drop_cnt    = '0;
`endif

endmodule
